// File: rtl/rx_client_fifo_pkg.sv
// rx_client_fifo_pkg: shared word layout and default sizes for the receive client FIFO
package rx_client_fifo_pkg;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int ADDR_W_DEF = 9;
  localparam int EOF_ADDR_W_DEF = 4;
  typedef struct packed {
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } rx_word_t;
endpackage

// File: rtl/rx_eof_fifo.sv
// rx_eof_fifo: synchronous FIFO of committed frame end pointers with head-of-queue view
module rx_eof_fifo #(
  parameter int W = 10,
  parameter int AW = 4
) (
  input  logic         rxclk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wp, rp;
  assign full = (wp - rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge rxclk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge rxclk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push && !full);
      rp <= rp + (AW+1)'(pop && !empty);
    end
endmodule

// File: rtl/rx_client_fifo.sv
// rx_client_fifo: store-and-forward receive buffer that releases only committed good frames
module rx_client_fifo
  import rx_client_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int EOF_ADDR_W = EOF_ADDR_W_DEF
) (
  input  logic              rxclk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [KEEP_W-1:0] rx_data_valid,
  input  logic              rx_good_frame,
  input  logic              rx_bad_frame,
  output logic [DATA_W-1:0] client_data,
  output logic [KEEP_W-1:0] client_keep,
  output logic              client_sof,
  output logic              client_eof,
  output logic              client_valid,
  input  logic              client_ready,
  output logic              frame_dropped,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_level
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  rx_word_t ram [2**ADDR_W];
  rx_word_t q_word;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, wr_ptr_next, q_addr, eof_head;
  logic full, empty, attempt, wr_en, ovf_hit, ovf_tag, tag_eff, active, commit, drop_now;
  logic eof_full, eof_empty, eof_pop, q_v, q_eof, adv_out, load_out, rd_en, sof_pend;
  assign full = (wr_ptr - rd_ptr) == DEPTH;
  assign empty = rd_ptr == commit_ptr;
  assign attempt = |rx_data_valid && !ovf_tag && !rx_bad_frame;
  assign wr_en = attempt && !full;
  assign ovf_hit = attempt && full;
  assign wr_ptr_next = wr_ptr + PW'(wr_en);
  assign tag_eff = ovf_tag || ovf_hit;
  // a tagged frame counts as non-empty even if none of its words reached the RAM
  assign active = (wr_ptr_next != commit_ptr) || tag_eff;
  assign commit = rx_good_frame && !rx_bad_frame && active && !tag_eff && !eof_full;
  assign drop_now = rx_bad_frame || (rx_good_frame && active && !commit);
  assign fifo_level = wr_ptr - rd_ptr;
  always_ff @(posedge rxclk)
    if (wr_en) ram[wr_ptr[ADDR_W-1:0]] <= '{keep: rx_data_valid, data: rx_data};
  always_ff @(posedge rxclk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      ovf_tag <= 1'b0;
      frame_dropped <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= drop_now ? commit_ptr : wr_ptr_next;
      commit_ptr <= commit ? wr_ptr_next : commit_ptr;
      ovf_tag <= (rx_good_frame || rx_bad_frame) ? 1'b0 : tag_eff;
      frame_dropped <= drop_now;
      overflow <= ovf_hit;
    end
  rx_eof_fifo #(.W(PW), .AW(EOF_ADDR_W)) u_eof (
    .rxclk(rxclk),
    .reset_n(reset_n),
    .push(commit),
    .din(wr_ptr_next - PW'(1)),
    .pop(eof_pop),
    .head(eof_head),
    .full(eof_full),
    .empty(eof_empty)
  );
  // RAM read register acts as prefetch; the client register is the holding stage
  assign adv_out = !client_valid || client_ready;
  assign load_out = q_v && adv_out;
  assign rd_en = !empty && (!q_v || adv_out);
  assign q_eof = !eof_empty && (q_addr == eof_head);
  assign eof_pop = load_out && q_eof;
  always_ff @(posedge rxclk)
    if (rd_en) q_word <= ram[rd_ptr[ADDR_W-1:0]];
  always_ff @(posedge rxclk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      q_v <= 1'b0;
      q_addr <= '0;
      sof_pend <= 1'b1;
      client_valid <= 1'b0;
      client_sof <= 1'b0;
      client_eof <= 1'b0;
      client_keep <= '0;
      client_data <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(rd_en);
      q_v <= rd_en || (q_v && !adv_out);
      if (rd_en) q_addr <= rd_ptr;
      client_valid <= load_out || (client_valid && !client_ready);
      if (load_out) begin
        client_data <= q_word.data;
        client_keep <= q_word.keep;
        client_sof <= sof_pend;
        client_eof <= q_eof;
        sof_pend <= q_eof;
      end
    end
endmodule

// File: tb/tb_rx_client_fifo.sv
// tb_rx_client_fifo: scoreboard bench for the receive client FIFO (ADDR_W=4)
module tb_rx_client_fifo;
  localparam int AW = 4;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic s; logic e;} wd_t;
  logic rxclk = 0, reset_n = 0, rx_good_frame = 0, rx_bad_frame = 0, client_ready = 1;
  logic [63:0] rx_data = '0;
  logic [7:0] rx_data_valid = '0;
  logic [63:0] client_data;
  logic [7:0] client_keep;
  logic client_sof, client_eof, client_valid, frame_dropped, overflow;
  logic [AW:0] fifo_level;
  int n_chk = 0, n_fail = 0, cyc = 0, drop_cnt = 0, ovf_cnt = 0, ovf_cyc = -1, good_cyc = 0;
  wd_t exp_q[$], got_q[$];
  int got_c[$], wcyc[$];

  rx_client_fifo #(.ADDR_W(AW), .EOF_ADDR_W(4)) dut (
    .rxclk(rxclk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame), .client_data(client_data),
    .client_keep(client_keep), .client_sof(client_sof), .client_eof(client_eof),
    .client_valid(client_valid), .client_ready(client_ready), .frame_dropped(frame_dropped),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;
  always begin
    @(posedge rxclk);
    #1;
    if (client_valid && client_ready) begin
      got_q.push_back('{client_data, client_keep, client_sof, client_eof});
      got_c.push_back(cyc);
    end
    if (frame_dropped) drop_cnt++;
    if (overflow) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge rxclk);
    #2;
  endtask

  task automatic wr(input logic [63:0] d, input logic [7:0] k, input logic g, input logic b);
    rx_data = d; rx_data_valid = k; rx_good_frame = g; rx_bad_frame = b;
    tick();
    rx_data = '0; rx_data_valid = '0; rx_good_frame = 0; rx_bad_frame = 0;
  endtask

  // mode: 0 good next cycle, 1 good with last word, 2 bad next cycle, 3 unterminated
  task automatic send(input int n, input logic [7:0] last_k, input int mode, input bit deliver);
    logic [63:0] d;
    logic [7:0] k;
    wcyc.delete();
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      k = (i == n - 1) ? last_k : 8'hFF;
      if (deliver) exp_q.push_back('{d: d, k: k, s: (i == 0), e: (i == n - 1)});
      wr(d, k, mode == 1 && i == n - 1, 1'b0);
      wcyc.push_back(cyc);
    end
    if (mode == 0 || mode == 2) wr('0, '0, mode == 0, mode == 2);
    good_cyc = cyc;
  endtask

  task automatic wait_got(input int n, input int max);
    for (int i = 0; i < max && got_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    n_chk++;
    if ({client_valid, client_sof, client_eof, frame_dropped, overflow} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {client_valid, client_sof, client_eof, frame_dropped, overflow});
    end
    n_chk++;
    if ({client_data, client_keep, fifo_level} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h/%h/%0d exp 0", client_data, client_keep, fifo_level);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_single_frame();
    int d0, c0;
    bit contig;
    wd_t g, e;
    d0 = drop_cnt;
    client_ready = 1;
    send(8, 8'h0F, 0, 1);
    wait_got(8, 50);
    n_chk++;
    if (got_q.size() != 8) begin n_fail++; $display("FAIL t1_count got %0d exp 8", got_q.size()); end
    c0 = got_c.size() > 0 ? got_c[0] : -1;
    n_chk++;
    if (c0 != good_cyc + 2) begin n_fail++; $display("FAIL t1_latency got cycle %0d exp %0d", c0, good_cyc + 2); end
    contig = 1;
    for (int i = 0; i < got_c.size(); i++) if (got_c[i] != c0 + i) contig = 0;
    n_chk++;
    if (!contig) begin n_fail++; $display("FAIL t1_contiguous got gaps exp none"); end
    for (int i = 0; i < 8; i++) begin
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL t1_word%0d got %h exp %h", i, g, e); end
    end
    got_c.delete();
    repeat (3) tick();
    n_chk++;
    if (drop_cnt != d0) begin n_fail++; $display("FAIL t1_no_drop got %0d exp %0d", drop_cnt, d0); end
    n_chk++;
    if (fifo_level !== '0) begin n_fail++; $display("FAIL t1_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_bad_frame();
    int d0;
    d0 = drop_cnt;
    send(5, 8'hFF, 2, 0);
    repeat (10) tick();
    n_chk++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL t2_no_output got %0d words exp 0", got_q.size()); end
    n_chk++;
    if (drop_cnt != d0 + 1) begin n_fail++; $display("FAIL t2_drop got %0d exp %0d", drop_cnt, d0 + 1); end
    n_chk++;
    if (fifo_level !== '0) begin n_fail++; $display("FAIL t2_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_overflow();
    int d0, o0, oc;
    wd_t g, e;
    d0 = drop_cnt;
    o0 = ovf_cnt;
    send(20, 8'hFF, 0, 0);
    oc = wcyc[16];
    repeat (10) tick();
    n_chk++;
    if (ovf_cnt != o0 + 1) begin n_fail++; $display("FAIL t3_ovf_count got %0d exp %0d", ovf_cnt, o0 + 1); end
    n_chk++;
    if (ovf_cyc != oc) begin n_fail++; $display("FAIL t3_ovf_cycle got %0d exp %0d", ovf_cyc, oc); end
    n_chk++;
    if (drop_cnt != d0 + 1) begin n_fail++; $display("FAIL t3_drop got %0d exp %0d", drop_cnt, d0 + 1); end
    n_chk++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL t3_no_output got %0d words exp 0", got_q.size()); end
    n_chk++;
    if (fifo_level !== '0) begin n_fail++; $display("FAIL t3_level got %0d exp 0", fifo_level); end
    send(3, 8'h03, 0, 1);
    wait_got(3, 50);
    for (int i = 0; i < 3; i++) begin
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL t3_after_word%0d got %h exp %h", i, g, e); end
    end
    got_c.delete();
  endtask

  task automatic test_back_to_back();
    logic pv, pr;
    wd_t po, cur, g, e;
    client_ready = 0;
    send(4, 8'h01, 0, 1);
    send(4, 8'h7F, 0, 1);
    pv = 0;
    pr = 1;
    for (int i = 0; i < 100 && got_q.size() < 8; i++) begin
      cur = '{client_data, client_keep, client_sof, client_eof};
      if (pv && !pr) begin
        n_chk++;
        if ({client_valid, cur} !== {1'b1, po}) begin
          n_fail++; $display("FAIL t4_stall_stable got %b/%h exp 1/%h", client_valid, cur, po);
        end
      end
      pv = client_valid;
      po = cur;
      pr = i[0];
      client_ready = pr;
      tick();
    end
    client_ready = 1;
    n_chk++;
    if (got_q.size() != 8) begin n_fail++; $display("FAIL t4_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL t4_word%0d got %h exp %h", i, g, e); end
    end
    got_c.delete();
  endtask

  task automatic test_wrap();
    wd_t g, e;
    client_ready = 1;
    send(14, 8'h3F, 1, 1);
    tick(); tick();
    send(14, 8'hFF, 1, 1);
    wait_got(28, 100);
    n_chk++;
    if (got_q.size() != 28) begin n_fail++; $display("FAIL t5_count got %0d exp 28", got_q.size()); end
    for (int i = 0; i < 28; i++) begin
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL t5_word%0d got %h exp %h", i, g, e); end
    end
    got_c.delete();
  endtask

  task automatic test_reset_mid();
    wd_t g, e;
    client_ready = 0;
    send(6, 8'hFF, 0, 1);
    repeat (4) tick();
    n_chk++;
    if (client_valid !== 1'b1) begin n_fail++; $display("FAIL t6_pre_valid got %b exp 1", client_valid); end
    send(3, 8'hFF, 3, 0);
    reset_n = 0;
    #1;
    n_chk++;
    if ({client_valid, client_sof, client_eof, frame_dropped, overflow} !== 5'b0) begin
      n_fail++; $display("FAIL t6_reset_flags got %b exp 00000", {client_valid, client_sof, client_eof, frame_dropped, overflow});
    end
    n_chk++;
    if ({client_data, client_keep, fifo_level} !== '0) begin
      n_fail++; $display("FAIL t6_reset_data got %h/%h/%0d exp 0", client_data, client_keep, fifo_level);
    end
    exp_q.delete();
    got_q.delete();
    got_c.delete();
    tick(); tick();
    reset_n = 1;
    tick();
    client_ready = 1;
    send(2, 8'h81, 0, 1);
    wait_got(2, 50);
    n_chk++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL t6_count got %0d exp 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL t6_word%0d got %h exp %h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
